// File: rtl/flux_out_demux_fifo.sv
// Tag-stripping demultiplexer: routes {tag, payload} tokens into per-flux FWFT FIFOs
// and returns a conservative registered full flag to the producing actor.
module flux_out_demux_fifo #(
  parameter int FLUX       = 2,
  parameter int DATA_WIDTH = 8,
  parameter int TAG_WIDTH  = (FLUX > 1) ? $clog2(FLUX) : 1,
  parameter int WIDTH      = DATA_WIDTH + TAG_WIDTH,
  parameter int DEPTH      = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_port_write,
  input  logic [WIDTH-1:0]                     in_port_datain,
  output logic                                 in_port_full,
  input  logic [FLUX-1:0]                      out_port_read,
  output logic [FLUX*DATA_WIDTH-1:0]           out_port_dataout,
  output logic [FLUX-1:0]                      out_port_empty,
  output logic [FLUX*($clog2(DEPTH)+1)-1:0]    out_port_count,
  output logic                                 err_overflow,
  output logic                                 err_badtag
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [CW-1:0] ALMOST_C  = CW'(DEPTH - 1);

  logic [TAG_WIDTH-1:0]  tag;
  logic [DATA_WIDTH-1:0] payload;
  logic                  bad_tag;
  logic [FLUX-1:0]       drop_vec;
  logic [FLUX-1:0]       full_nxt_vec;

  assign tag     = in_port_datain[WIDTH-1:DATA_WIDTH];
  assign payload = in_port_datain[DATA_WIDTH-1:0];

  // Out-of-range tags can only exist when FLUX does not fill the tag space.
  if (FLUX < (2 ** TAG_WIDTH)) begin : g_badtag
    assign bad_tag = in_port_write && (tag >= TAG_WIDTH'(FLUX));
  end else begin : g_nobadtag
    assign bad_tag = 1'b0;
  end

  for (genvar f = 0; f < FLUX; f++) begin : g_flux
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         rd_nxt;
    logic [CW-1:0]         count;
    logic [CW-1:0]         count_nxt;
    logic [DATA_WIDTH-1:0] head_q;
    logic [DATA_WIDTH-1:0] head_nxt;
    logic                  sel;
    logic                  push;
    logic                  pop;

    // The head register is preloaded with whatever will sit at rd_ptr after the
    // edge, so a freshly written word into an empty FIFO becomes the head directly.
    always_comb begin
      sel       = in_port_write && (tag == TAG_WIDTH'(f));
      push      = sel && (count < DEPTH_C);
      pop       = out_port_read[f] && (count != '0);
      count_nxt = count;
      if (push && !pop)
        count_nxt = count + 1'b1;
      else if (pop && !push)
        count_nxt = count - 1'b1;
      rd_nxt   = pop ? rd_ptr + 1'b1 : rd_ptr;
      head_nxt = head_q;
      if (count_nxt != '0)
        head_nxt = (push && (rd_nxt == wr_ptr)) ? payload : mem[rd_nxt];
    end

    always_ff @(posedge clk) begin
      if (push)
        mem[wr_ptr] <= payload;
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
        head_q <= '0;
      end else begin
        if (push)
          wr_ptr <= wr_ptr + 1'b1;
        rd_ptr <= rd_nxt;
        count  <= count_nxt;
        head_q <= head_nxt;
      end
    end

    assign drop_vec[f]     = sel && !push;
    assign full_nxt_vec[f] = (count_nxt >= ALMOST_C);
    assign out_port_dataout[f*DATA_WIDTH +: DATA_WIDTH] = head_q;
    assign out_port_count[f*CW +: CW]                   = count;
    assign out_port_empty[f]                            = (count == '0);
  end

  // Full asserts one slot early because the actor reacts a cycle late.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_port_full <= 1'b0;
      err_overflow <= 1'b0;
      err_badtag   <= 1'b0;
    end else begin
      in_port_full <= |full_nxt_vec;
      if (|drop_vec)
        err_overflow <= 1'b1;
      if (bad_tag)
        err_badtag <= 1'b1;
    end
  end

endmodule

// File: doc/flux_out_demux_fifo.md
Name: flux_out_demux_fifo

Overview:
- Downstream stage of the tagged multi-flux actors (SDF/CSDF PICK wrappers).
- Consumes the single tagged output stream `{tag, payload}`.
- Strips the tag and routes each payload into a per-flux FIFO.
- Per-flux sinks drain their FIFO independently, and the block returns one aggregate full signal to the actor.

Parameters:
- FLUX, 2, number of fluxes (tag values 0..FLUX-1).
- DATA_WIDTH, 8, payload width.
- TAG_WIDTH, $clog2(FLUX) (minimum 1), tag width; the tag occupies the MSBs of the input word.
- WIDTH, DATA_WIDTH+TAG_WIDTH, input token width.
- DEPTH, 4, entries per flux FIFO; power of two, at least 2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- in_port_write  in  1  a token is presented on in_port_datain.
- in_port_datain  in  WIDTH  bits [WIDTH-1:DATA_WIDTH] are the tag; bits [DATA_WIDTH-1:0] are the payload.
- in_port_full  out  1  back-pressure to the actor; connects to the actor's out_port_full.
- out_port_read  in  FLUX  per-flux pop request.
- out_port_dataout  out  FLUX*DATA_WIDTH  per-flux head payload; flux f occupies slice [f*DATA_WIDTH +: DATA_WIDTH].
- out_port_empty  out  FLUX  per-flux FIFO empty.
- out_port_count  out  FLUX*($clog2(DEPTH)+1)  per-flux occupancy.
- err_overflow  out  1  sticky: a write was dropped because the target FIFO was full.
- err_badtag  out  1  sticky: a write was dropped because its tag was >= FLUX.

Behaviour:
- Reset (rst=0, asynchronous):
  - All FIFO pointers and counts go to 0.
  - out_port_empty goes to all 1s; in_port_full goes to 0; both err flags go to 0.
  - out_port_dataout goes to 0.
  - FIFO contents are not reset.
  - Reset asserted mid-operation discards every stored token immediately.
- Write:
  - On a clk edge with in_port_write=1 and tag t<FLUX:
    - if FIFO t has count<DEPTH, the payload is stored at its tail and count[t] increments;
    - otherwise the token is dropped, FIFO t is unchanged, and err_overflow is set.
  - A tag >= FLUX (only possible when FLUX is not a power of two) drops the token and sets err_badtag.
- in_port_full:
  - Registered.
  - Equals 1 when any FIFO count will be >= DEPTH-1 after the current edge.
  - This one-slot margin absorbs the actor's one-cycle reaction to full.
  - It is conservative because the actor does not know the next tag in advance.
- Read (first-word-fall-through):
  - out_port_dataout slice f always shows the head of FIFO f when out_port_empty[f]=0.
  - When the FIFO is empty, the slice holds its last value (0 after reset).
  - out_port_read[f]=1 with the FIFO non-empty pops the head at the edge; the next entry is visible in the following cycle.
  - A read while empty is ignored and count stays 0; there is no error flag for this.
- Latency: a token written at edge N is visible at its flux's output after edge N, i.e. the empty flag falls one cycle after the write.
- Simultaneous read and write on the same FIFO:
  - Both take effect and the count is unchanged.
  - On an empty FIFO, the written word becomes the head after the edge; no bypass in the same cycle.
  - On a full FIFO, the write is still dropped and err_overflow is set; the read pops. The decision is based on the pre-edge count.
- Writes and reads to different fluxes are fully independent in the same cycle.
- Pointers wrap modulo DEPTH.
- count ranges 0..DEPTH; it never exceeds DEPTH and never underflows.
- The err flags clear only on reset.
- Tag bits are not forwarded; the flux identity is the slice index.

Test Plan:
- Reset then idle:
  - Response: out_port_empty=2'b11, in_port_full=0, counts 0, err flags 0.
  - Apply rst=0 mid-stream with 3 tokens queued: all counts drop to 0 without waiting for clk.
- Actor result routing:
  - Stimulus: write {0,8'd4} then {1,8'd4}.
  - Response: slice0=8'h04 with empty[0]=0; slice1=8'h04 with empty[1]=0; count=1 each.
  - Popping both gives empty=2'b11.
- Fill flux 0, no reads:
  - Stimulus: write {0,8'd1..8'd4}.
  - Response: in_port_full=1 after the 3rd write.
  - A 5th write {0,8'd5} with write forced is dropped and sets err_overflow=1; the FIFO still holds 1,2,3,4 in order.
- Simultaneous read and write:
  - Stimulus: flux1 count=2 (heads 8'hA0, 8'hA1); same cycle: read[1]=1 and write {1,8'hA2}.
  - Response: count stays 2, head becomes 8'hA1, and the next pop gives 8'hA2.
- Wrap-around:
  - Stimulus: on flux 0, 10 interleaved write/read pairs with payloads 0..9.
  - Response: outputs come out in order 0..9, count never exceeds DEPTH, err_overflow=0.
- Empty read: read[0]=1 with an empty FIFO leaves count 0, empty[0]=1, and both err flags 0.
